// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file dump reader.
// Addresses wrap modulo NUM_REGS through wrapAdd().
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND0,
        SEND1,
        DONE
    } dump_state_t;

    function automatic logic [ADDR_W-1:0] wrapAdd(
        input logic [ADDR_W-1:0] a,
        input int                k
    );
        int t;
        t = (int'(a) + k) % NUM_REGS;
        return ADDR_W'(t);
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output word stream of the dump reader: valid/ready with data and address.
// master drives the words, slave accepts them.
interface regfile_dump_reader_if;
    import regfile_pkg::*;

    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic [ADDR_W-1:0] outAddr;

    modport master (
        output outValid,
        output outData,
        output outAddr,
        input  outReady
    );

    modport slave (
        input  outValid,
        input  outData,
        input  outAddr,
        output outReady
    );

endinterface

// File: rtl/regfile_dump_reader_checksum.sv
// XOR accumulator over accepted dump words (built with REGDUMP_CHECKSUM_EN).
module regdump_checksum
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum ^ data;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Sweeps a window of the 32x32 register file two words per fetch and streams
// them out; optional XOR checksum when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] regReadSel0,
    output logic [ADDR_W-1:0] regReadSel1,
    input  logic [DATA_W-1:0] regReadData0,
    input  logic [DATA_W-1:0] regReadData1,
    regfile_dump_reader_if.master dumpOut,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    dump_state_t state;
    dump_state_t stateNext;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addrP1;
    logic [ADDR_W-1:0] sel0Q;
    logic [ADDR_W-1:0] sel1Q;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] word0;
    logic [DATA_W-1:0] word1;
    logic              startAcc;
    logic              accept;
    logic              lastWord;

    assign addrP1   = wrapAdd(addr, 1);
    assign startAcc = (state == IDLE) && start;
    assign accept   = dumpOut.outValid && dumpOut.outReady;
    assign lastWord = (remaining == (ADDR_W+1)'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (count != '0) ? FETCH : DONE;
                end
            end
            FETCH: stateNext = SEND0;
            SEND0: begin
                if (accept) begin
                    stateNext = lastWord ? DONE : SEND1;
                end
            end
            SEND1: begin
                if (accept) begin
                    stateNext = lastWord ? DONE : FETCH;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            word0     <= '0;
            word1     <= '0;
            sel0Q     <= '0;
            sel1Q     <= '0;
        end else begin
            if (startAcc) begin
                addr      <= startAddr;
                remaining <= count;
            end
            if (state == FETCH) begin
                word0 <= regReadData0;
                word1 <= regReadData1;
                sel0Q <= addr;
                sel1Q <= addrP1;
            end
            if (accept) begin
                remaining <= remaining - 1'b1;
                if ((state == SEND1) && !lastWord) begin
                    addr <= wrapAdd(addr, 2);
                end
            end
        end
    end

    // Selects track addr only while fetching so the file sees a quiet bus otherwise.
    assign regReadSel0 = (state == FETCH) ? addr   : sel0Q;
    assign regReadSel1 = (state == FETCH) ? addrP1 : sel1Q;

    assign dumpOut.outValid = (state == SEND0) || (state == SEND1);
    assign dumpOut.outData  = (state == SEND1) ? word1  : word0;
    assign dumpOut.outAddr  = (state == SEND1) ? addrP1 : addr;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef REGDUMP_CHECKSUM_EN
    regdump_checksum uChecksum (
        .clk    (clk),
        .reset  (reset),
        .clear  (startAcc),
        .enable (accept),
        .data   (dumpOut.outData),
        .sum    (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader with a queue-based reference model.
// Define REGDUMP_CHECKSUM_EN to build the checksum variant.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] startAddr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] sel0;
    logic [ADDR_W-1:0] sel1;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    regfile_dump_reader_if dumpBus();

    logic [DATA_W-1:0] rf [NUM_REGS];
    assign rd0 = rf[sel0];
    assign rd1 = rf[sel1];

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .startAddr    (startAddr),
        .count        (count),
        .regReadSel0  (sel0),
        .regReadSel1  (sel1),
        .regReadData0 (rd0),
        .regReadData1 (rd1),
        .dumpOut      (dumpBus),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } item_t;

    item_t             expQ [$];
    item_t             logQ [$];
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] modelSum = '0;
    int                readyMode = 0;
    logic              stallPrev = 1'b0;
    logic              donePrev = 1'b0;
    logic [DATA_W-1:0] prevData;
    logic [ADDR_W-1:0] prevAddr;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] expSum();
`ifdef REGDUMP_CHECKSUM_EN
        return modelSum;
`else
        return '0;
`endif
    endfunction

    // Sink readiness: always, toggling, or random.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       dumpBus.outReady = 1'b1;
            1:       dumpBus.outReady = ~dumpBus.outReady;
            default: dumpBus.outReady = ($urandom % 4) != 0;
        endcase
    end

    // Single compare process against the model queue.
    always @(negedge clk) begin
        if (reset) begin
            stallPrev = 1'b0;
            donePrev  = 1'b0;
        end else begin
            if (stallPrev) begin
                check("stall_valid", 32'(dumpBus.outValid), 32'd1);
                check("stall_data", dumpBus.outData, prevData);
                check("stall_addr", 32'(dumpBus.outAddr), 32'(prevAddr));
            end
            if (dumpBus.outValid) begin
                if (expQ.size() == 0) begin
                    check("spurious_valid", 32'(dumpBus.outValid), 32'd0);
                end else begin
                    check("data", dumpBus.outData, expQ[0].d);
                    check("addr", 32'(dumpBus.outAddr), 32'(expQ[0].a));
                    check("busy_in_send", 32'(busy), 32'd1);
                    if (dumpBus.outReady) begin
                        logQ.push_back('{a: dumpBus.outAddr,
                                         d: dumpBus.outData});
                        modelSum ^= expQ[0].d;
                        void'(expQ.pop_front());
                    end
                end
            end
            if (done) begin
                check("done_drained", 32'(expQ.size()), 32'd0);
                check("done_checksum", checksum, expSum());
                check("done_single", 32'(donePrev), 32'd0);
            end
            stallPrev = dumpBus.outValid && !dumpBus.outReady;
            prevData  = dumpBus.outData;
            prevAddr  = dumpBus.outAddr;
            donePrev  = done;
        end
    end

    task automatic launch(input int sa, input int cnt);
        @(posedge clk);
        #1;
        expQ.delete();
        logQ.delete();
        modelSum = '0;
        for (int i = 0; i < cnt; i++) begin
            expQ.push_back('{a: ADDR_W'((sa + i) % NUM_REGS),
                             d: rf[(sa + i) % NUM_REGS]});
        end
        startAddr = ADDR_W'(sa);
        count     = (ADDR_W+1)'(cnt);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runDump(input int sa, input int cnt, output int lat);
        launch(sa, cnt);
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #2;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("done_seen", 32'(done), 32'd1);
        check("word_count", 32'(logQ.size()), 32'(cnt));
        @(negedge clk);
        #2;
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        dumpBus.outReady = 1'b1;
        reset     = 1'b1;
        start     = 1'b0;
        startAddr = '0;
        count     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] = 32'hFFFF000F - 32'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(dumpBus.outValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", dumpBus.outData, 32'd0);
        check("rst_addr", 32'(dumpBus.outAddr), 32'd0);
        check("rst_sel0", 32'(sel0), 32'd0);
        check("rst_sel1", 32'(sel1), 32'd0);
        check("rst_cks", checksum, 32'd0);
        reset = 1'b0;

        // Window 0..3, sink always ready.
        readyMode = 0;
        runDump(0, 4, lat);
        check("lat_cnt4", 32'(lat), 32'd6);
        for (int i = 0; i < 4 && i < logQ.size(); i++) begin
            check("lit0_addr", 32'(logQ[i].a), 32'(i));
            check("lit0_data", logQ[i].d, 32'hFFFF000F - 32'(i));
        end

        // Wrap past register 31.
        runDump(30, 4, lat);
        begin
            int wa [4] = '{30, 31, 0, 1};
            for (int i = 0; i < 4 && i < logQ.size(); i++) begin
                check("wrap_addr", 32'(logQ[i].a), 32'(wa[i]));
                check("wrap_data", logQ[i].d,
                      32'hFFFF000F - 32'(wa[i]));
            end
        end

        // Odd count with a stalling sink.
        readyMode = 1;
        runDump(0, 3, lat);
        for (int i = 0; i < 3 && i < logQ.size(); i++) begin
            check("odd_addr", 32'(logQ[i].a), 32'(i));
        end

        // Empty window.
        readyMode = 0;
        runDump(5, 0, lat);
        check("lat_cnt0", 32'(lat), 32'd0);

        // Checksum of the first two words.
        runDump(0, 2, lat);
`ifdef REGDUMP_CHECKSUM_EN
        check("cks_literal", checksum, 32'h0000_0001);
`else
        check("cks_literal", checksum, 32'h0);
`endif

        // Abort with reset while the second word of a pair is presented.
        launch(0, 6);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (dumpBus.outValid && dumpBus.outAddr == 5'd1) break;
        end
        check("reach_send1", 32'(dumpBus.outValid && dumpBus.outAddr == 5'd1),
              32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_valid", 32'(dumpBus.outValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            check("abort_no_done", 32'(done), 32'd0);
        end
        runDump(0, 4, lat);

        // Full sweep from a random base.
        readyMode = 2;
        runDump(int'($urandom_range(0, 31)), 32, lat);

        // Randomized windows, contents and sink behaviour.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] = $urandom;
            end
            readyMode = int'($urandom_range(0, 2));
            runDump(int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 32)), lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
